// File: rtl/dunit_loader.sv
// dunit_loader: UART-driven debug unit for the pipeline.
//   'L' (0x4C) loads instruction words into IMEM (MSB-first bytes,
//   terminated by 0xFFFFFFFF or a full IMEM). 'R' (0x52) runs until halt,
//   'S' (0x53) steps one cycle. Both end with a dump of the register file
//   over the transmitter.
// Optional feature: define DUNIT_MEM_DUMP_EN to append DMEM_DUMP_WORDS
// data-memory words to the dump.
// Handshakes: i_rx_valid is a one-cycle strobe qualifying i_rx_data and has
// no back-pressure; o_tx_start is a one-cycle strobe qualifying o_tx_data.
// Once started, a byte is owned by the transmitter until it returns a
// one-cycle i_tx_done. No new start is issued before that done.
module dunit_loader #(
  parameter int NB_REG          = 32,
  parameter int NB_ADDR         = 5,
  parameter int IMEM_DEPTH      = 256,
  parameter int DMEM_DUMP_WORDS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_dunit_reg,
  input  logic [NB_REG-1:0] i_dunit_mem_data,
  output logic              o_dunit_clk_en,
  output logic              o_dunit_reset_pc,
  output logic              o_dunit_w_mem,
  output logic [NB_REG-1:0] o_dunit_addr,
  output logic [NB_REG-1:0] o_dunit_data_if,
  output logic [2:0]        dbg_state
);

  localparam int NUM_REGS  = 1 << NB_ADDR;
`ifdef DUNIT_MEM_DUMP_EN
  localparam int NUM_ITEMS = NUM_REGS + DMEM_DUMP_WORDS;
`else
  localparam int NUM_ITEMS = NUM_REGS;
`endif
  localparam int IW = $clog2(NUM_ITEMS);
  localparam int WW = $clog2(IMEM_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    LOAD_WR   = 3'd2,
    RUN       = 3'd3,
    STEP      = 3'd4,
    DUMP_SEL  = 3'd5,
    DUMP_TX   = 3'd6,
    DUMP_WAIT = 3'd7
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WW-1:0]     word_idx;
  logic [1:0]        byte_cnt;
  logic [NB_REG-1:0] shreg;
  logic [NB_REG-1:0] tx_word;
  logic [1:0]        tx_cnt;
  logic [IW-1:0]     item;
  logic              sel_phase;
  logic              halt_pend;
  logic [NB_REG-1:0] sel_addr;
  logic [NB_REG-1:0] sel_data;

  // Dump source select: registers first, then (optionally) data memory.
`ifdef DUNIT_MEM_DUMP_EN
  logic          in_mem;
  logic [IW-1:0] mem_idx;
  assign in_mem   = ({1'b0, item} >= (IW+1)'(NUM_REGS));
  assign mem_idx  = item - IW'(NUM_REGS);
  assign sel_addr = in_mem ? NB_REG'({mem_idx, 2'b00}) : NB_REG'(item);
  assign sel_data = in_mem ? i_dunit_mem_data : i_dunit_reg;
`else
  logic unused_mem_data;
  assign unused_mem_data = ^i_dunit_mem_data;
  assign sel_addr = NB_REG'(item);
  assign sel_data = i_dunit_reg;
`endif

  assign o_tx_data = tx_word[NB_REG-1 -: 8];
  assign dbg_state = state;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and output decode.
  always_comb begin
    next_state       = state;
    o_tx_start       = 1'b0;
    o_dunit_clk_en   = 1'b0;
    o_dunit_reset_pc = 1'b0;
    o_dunit_w_mem    = 1'b0;
    o_dunit_addr     = '0;
    o_dunit_data_if  = '0;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h4C:   next_state = LOAD;
            8'h52:   next_state = RUN;
            8'h53:   next_state = STEP;
            default: next_state = IDLE;
          endcase
        end
      end
      LOAD: begin
        o_dunit_reset_pc = 1'b1;
        if (i_rx_valid && byte_cnt == 2'd3) next_state = LOAD_WR;
      end
      LOAD_WR: begin
        o_dunit_reset_pc = 1'b1;
        o_dunit_w_mem    = 1'b1;
        o_dunit_addr     = NB_REG'({word_idx, 2'b00});
        o_dunit_data_if  = shreg;
        // Terminator word is written before leaving; a full IMEM stops the load.
        if (shreg == '1 || word_idx == WW'(IMEM_DEPTH - 1)) next_state = IDLE;
        else                                                next_state = LOAD;
      end
      RUN: begin
        o_dunit_clk_en = 1'b1;
        if (i_halt || halt_pend) next_state = DUMP_SEL;
      end
      STEP: begin
        o_dunit_clk_en = 1'b1;
        next_state     = DUMP_SEL;
      end
      DUMP_SEL: begin
        // Address held for two cycles: issue, then capture the 1-cycle-late data.
        o_dunit_addr = sel_addr;
        if (sel_phase) next_state = DUMP_TX;
      end
      DUMP_TX: begin
        o_tx_start = 1'b1;
        next_state = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (i_tx_done) begin
          if (tx_cnt != 2'd3)                next_state = DUMP_TX;
          else if (item == IW'(NUM_ITEMS-1)) next_state = IDLE;
          else                               next_state = DUMP_SEL;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load assembly, write index, dump word and byte sequencing.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_idx  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      tx_word   <= '0;
      tx_cnt    <= '0;
      item      <= '0;
      sel_phase <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          item      <= '0;
          sel_phase <= 1'b0;
          tx_cnt    <= '0;
          if (i_rx_valid && i_rx_data == 8'h4C) begin
            word_idx <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
          end
          // A halt arriving together with the run command is remembered.
          if (i_rx_valid && i_rx_data == 8'h52) halt_pend <= i_halt;
        end
        LOAD: begin
          if (i_rx_valid) begin
            shreg    <= {shreg[NB_REG-9:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        LOAD_WR: word_idx <= word_idx + 1'b1;
        RUN:     halt_pend <= 1'b0;
        DUMP_SEL: begin
          sel_phase <= ~sel_phase;
          if (sel_phase) begin
            tx_word <= sel_data;
            tx_cnt  <= '0;
          end
        end
        DUMP_WAIT: begin
          if (i_tx_done) begin
            tx_word <= tx_word << 8;
            tx_cnt  <= tx_cnt + 2'd1;
            if (tx_cnt == 2'd3) item <= item + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dunit_loader.sv
// Testbench for dunit_loader: random register/memory contents, a transmitter
// responder with variable done delay, and scoreboards for IMEM writes and
// dump bytes. Honours DUNIT_MEM_DUMP_EN for the expected dump length.
module tb_dunit_loader;

  localparam int NB_REG     = 32;
  localparam int NB_ADDR    = 5;
  localparam int IMEM_DEPTH = 8;
  localparam int DMEM_WORDS = 16;
`ifdef DUNIT_MEM_DUMP_EN
  localparam int DUMP_BYTES = 4 * (32 + DMEM_WORDS);
`else
  localparam int DUMP_BYTES = 128;
`endif

  logic              clk = 1'b0;
  logic              i_reset;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              i_tx_done;
  logic              i_halt;
  logic [NB_REG-1:0] i_dunit_reg;
  logic [NB_REG-1:0] i_dunit_mem_data;
  logic              o_dunit_clk_en;
  logic              o_dunit_reset_pc;
  logic              o_dunit_w_mem;
  logic [NB_REG-1:0] o_dunit_addr;
  logic [NB_REG-1:0] o_dunit_data_if;
  logic [2:0]        dbg_state;

  dunit_loader #(
    .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DUMP_WORDS(DMEM_WORDS)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .i_halt(i_halt),
    .i_dunit_reg(i_dunit_reg), .i_dunit_mem_data(i_dunit_mem_data),
    .o_dunit_clk_en(o_dunit_clk_en), .o_dunit_reset_pc(o_dunit_reset_pc),
    .o_dunit_w_mem(o_dunit_w_mem), .o_dunit_addr(o_dunit_addr),
    .o_dunit_data_if(o_dunit_data_if), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_tx_q[$];
  logic [63:0] exp_wr_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] reg_val[32];
  logic [31:0] mem_val[DMEM_WORDS];
  int          clk_en_cnt = 0;
  int          tx_cnt = 0;
  int          rpc_low_cnt = 0;
  int          tx_delay = 1;
  bit          outstanding = 0;
  bit          in_load = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Register file and data memory models: one-cycle read latency.
  always @(posedge clk) begin
    i_dunit_reg      <= reg_val[o_dunit_addr[4:0]];
    i_dunit_mem_data <= mem_val[o_dunit_addr[5:2]];
  end

  // Transmitter model: answers each start with a done after tx_delay cycles.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (o_tx_start && !i_reset) begin
        repeat (tx_delay) @(negedge clk);
        i_tx_done   = 1'b1;
        outstanding = 0;
      end
    end
  end

  // Monitor: compares writes and transmitted bytes against the queues.
  always @(negedge clk) begin
    if (o_dunit_clk_en) clk_en_cnt++;
    if (in_load && !o_dunit_reset_pc) rpc_low_cnt++;
    if (o_dunit_w_mem) begin
      if (exp_wr_q.size() == 0) check("wr_unexpected", {o_dunit_addr, o_dunit_data_if}, 64'h0);
      else check("imem_write", {o_dunit_addr, o_dunit_data_if}, exp_wr_q.pop_front());
    end
    if (o_tx_start) begin
      tx_cnt++;
      check("tx_start_before_done", {63'h0, outstanding}, 64'h0);
      outstanding = 1;
      if (exp_tx_q.size() == 0) check("tx_unexpected", {56'h0, o_tx_data}, 64'h100);
      else check("tx_byte", {56'h0, o_tx_data}, {56'h0, exp_tx_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    exp_tx_q.delete();
    outstanding = 0;
    @(negedge clk);
    check("rst_tx_start", {63'h0, o_tx_start}, 64'h0);
    check("rst_clk_en", {63'h0, o_dunit_clk_en}, 64'h0);
    i_reset = 1'b0;
  endtask

  // Expected load behaviour: words written in order from address 0 until the
  // terminator word has been written or IMEM is full.
  task automatic run_load();
    int nwr;
    bit stop;
    bit last;
    nwr  = 0;
    stop = 0;
    foreach (ld_q[i]) begin
      if (!stop && nwr < IMEM_DEPTH) begin
        exp_wr_q.push_back({32'(nwr * 4), ld_q[i]});
        nwr++;
        if (ld_q[i] == 32'hFFFF_FFFF) stop = 1;
      end
    end
    send_byte(8'h4C, $urandom_range(1, 3));
    in_load     = 1;
    rpc_low_cnt = 0;
    foreach (ld_q[i]) begin
      for (int b = 3; b >= 0; b--) begin
        last = (i == nwr - 1) && (b == 0);
        send_byte(ld_q[i][8*b +: 8], last ? 0 : $urandom_range(1, 3));
        if (last) begin
          in_load = 0;
          @(negedge clk);
        end
      end
    end
    in_load = 0;
    repeat (4) @(negedge clk);
    check("load_writes_left", 64'(exp_wr_q.size()), 64'h0);
    check("load_reset_pc_low", 64'(rpc_low_cnt), 64'h0);
    check("post_load_reset_pc", {63'h0, o_dunit_reset_pc}, 64'h0);
    check("post_load_state", {61'h0, dbg_state}, 64'h0);
    ld_q.delete();
  endtask

  task automatic push_dump();
    for (int n = 0; n < 32; n++)
      for (int b = 3; b >= 0; b--) exp_tx_q.push_back(reg_val[n][8*b +: 8]);
`ifdef DUNIT_MEM_DUMP_EN
    for (int n = 0; n < DMEM_WORDS; n++)
      for (int b = 3; b >= 0; b--) exp_tx_q.push_back(mem_val[n][8*b +: 8]);
`endif
  endtask

  function automatic logic [7:0] noise_byte();
    logic [7:0] tbl[5];
    tbl = '{8'h4C, 8'h52, 8'h53, 8'h41, 8'hFF};
    return tbl[$urandom_range(0, 4)];
  endfunction

  task automatic wait_dump(input int budget, input bit noise);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (noise && exp_tx_q.size() > 0 && $urandom_range(0, 5) == 0) begin
        i_rx_valid = 1'b1;
        i_rx_data  = noise_byte();
      end else begin
        i_rx_valid = 1'b0;
      end
      if (exp_tx_q.size() == 0 && !outstanding) begin
        ok = 1;
        break;
      end
    end
    i_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("dump_timeout", {63'h0, ok}, 64'h1);
  endtask

  // cmd 0x53 steps; cmd 0x52 runs, halting d cycles after RUN is entered
  // (d+1 enabled cycles) or together with the command byte (one cycle).
  task automatic run_dump(input logic [7:0] cmd, input int d, input bit coincide,
                          input bit noise, input int exp_clk);
    clk_en_cnt = 0;
    tx_cnt     = 0;
    push_dump();
    @(negedge clk);
    i_rx_data  = cmd;
    i_rx_valid = 1'b1;
    i_halt     = coincide;
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    if (cmd == 8'h52 && !coincide) begin
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        i_rx_valid = noise && ($urandom_range(0, 3) == 0);
        i_rx_data  = noise_byte();
      end
      i_rx_valid = 1'b0;
      i_halt     = 1'b1;
      @(negedge clk);
      i_halt = 1'b0;
    end
    wait_dump(DUMP_BYTES * (tx_delay + 6) + 200, noise);
    check("clk_en_cycles", 64'(clk_en_cnt), 64'(exp_clk));
    check("dump_byte_count", 64'(tx_cnt), 64'(DUMP_BYTES));
    check("post_dump_state", {61'h0, dbg_state}, 64'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_reset    = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    for (int n = 0; n < 32; n++) reg_val[n] = $urandom;
    for (int n = 0; n < DMEM_WORDS; n++) mem_val[n] = $urandom;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_state", {61'h0, dbg_state}, 64'h0);
    check("rst_outputs", {58'h0, o_tx_start, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem, 2'b00}, 64'h0);
    check("rst_addr_data", {o_dunit_addr, o_dunit_data_if}, 64'h0);
    check("rst_tx_data", {56'h0, o_tx_data}, 64'h0);
    i_reset = 1'b0;
    @(negedge clk);

    // Directed load.
    ld_q = '{32'h0800_0010, 32'h2006_0000, 32'hFFFF_FFFF};
    run_load();

    // Random loads, each with a terminator.
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) ld_q.push_back($urandom & 32'h7FFF_FFFF);
      ld_q.push_back(32'hFFFF_FFFF);
      run_load();
    end

    // IMEM full: 10 words without terminator, only 8 written, rest ignored.
    for (int i = 0; i < 10; i++) ld_q.push_back(32'h0101_0101 * (i + 1));
    run_load();

    // Unknown command in IDLE is ignored.
    clk_en_cnt = 0;
    send_byte(8'h41, 5);
    check("ignore_cmd_state", {61'h0, dbg_state}, 64'h0);
    check("ignore_cmd_clk_en", 64'(clk_en_cnt), 64'h0);

    // Step with reg n = 0x100 + n.
    for (int n = 0; n < 32; n++) reg_val[n] = 32'h100 + n;
    tx_delay = 2;
    run_dump(8'h53, 0, 0, 0, 1);

    // Run, halt 20 cycles into RUN.
    tx_delay = 1;
    run_dump(8'h52, 20, 0, 0, 21);

    // Halt together with the run command.
    run_dump(8'h52, 0, 1, 0, 1);

    // Random runs with rx noise during RUN and the dump.
    for (int t = 0; t < 3; t++) begin
      int d;
      for (int n = 0; n < 32; n++) reg_val[n] = $urandom;
      for (int n = 0; n < DMEM_WORDS; n++) mem_val[n] = $urandom;
      d = $urandom_range(0, 30);
      tx_delay = $urandom_range(1, 5);
      run_dump(8'h52, d, 0, 1, d + 1);
    end

    // Back-pressure: done 50 cycles after each start.
    tx_delay = 50;
    run_dump(8'h53, 0, 0, 1, 1);
    tx_delay = 1;

    // Reset after two load bytes; next load restarts at address 0.
    send_byte(8'h4C, 1);
    send_byte(8'hAB, 1);
    send_byte(8'hCD, 1);
    pulse_reset();
    ld_q = '{32'hCAFE_0001, 32'hFFFF_FFFF};
    run_load();

    // Reset during RUN drops clk_en.
    send_byte(8'h52, 4);
    check("run_clk_en_high", {63'h0, o_dunit_clk_en}, 64'h1);
    pulse_reset();
    clk_en_cnt = 0;
    tx_cnt     = 0;
    repeat (20) @(negedge clk);
    check("run_reset_clk_en", 64'(clk_en_cnt), 64'h0);
    check("run_reset_tx", 64'(tx_cnt), 64'h0);

    // Reset mid-dump aborts transmission.
    tx_delay = 2;
    push_dump();
    send_byte(8'h53, 0);
    for (int c = 0; c < 500 && tx_cnt < 10; c++) @(negedge clk);
    check("mid_dump_progress", {63'h0, tx_cnt >= 10}, 64'h1);
    pulse_reset();
    tx_cnt     = 0;
    clk_en_cnt = 0;
    repeat (300) @(negedge clk);
    check("dump_reset_tx", 64'(tx_cnt), 64'h0);
    check("dump_reset_clk_en", 64'(clk_en_cnt), 64'h0);
    check("dump_reset_state", {61'h0, dbg_state}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
